// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle HI/LO multiply/divide unit with MIPS-style MT/MADD/MSUB ops.
// Results are computed from captured operands and committed on the last busy edge.
module muldiv_unit #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic             flush,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             stall_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int W2 = 2 * WIDTH;

    logic [5:0]       cnt;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             is_long, is_div, accept, q_div, q_sdiv, q_sx, wr_en;
    logic [WIDTH-1:0] ma, mb, dvs, uq, ur, dq, dr;
    logic [W2-1:0]    acc, prod, res;

    assign busy = cnt != 6'd0;

    always_comb begin
        is_long   = op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd8, 4'd9};
        is_div    = op == 4'd2 || op == 4'd3;
        accept    = start && !flush && !busy && op <= 4'd9;
        stall_req = !reset && (busy || (start && !flush && is_long));
    end

    // Signed forms sign-extend both factors; the low 2*WIDTH bits of the product are exact.
    always_comb begin
        q_sx = op_q inside {4'd0, 4'd6, 4'd8};
        prod = {{WIDTH{q_sx & a_q[WIDTH-1]}}, a_q} * {{WIDTH{q_sx & b_q[WIDTH-1]}}, b_q};
    end

    // Signed divide runs on magnitudes; min_int / -1 falls out as quotient min_int, remainder 0.
    always_comb begin
        q_div  = op_q == 4'd2 || op_q == 4'd3;
        q_sdiv = op_q == 4'd2;
        ma     = (q_sdiv && a_q[WIDTH-1]) ? -a_q : a_q;
        mb     = (q_sdiv && b_q[WIDTH-1]) ? -b_q : b_q;
        dvs    = (mb == '0) ? WIDTH'(1) : mb;
        uq     = ma / dvs;
        ur     = ma % dvs;
        dq     = (q_sdiv && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -uq : uq;
        dr     = (q_sdiv && a_q[WIDTH-1]) ? -ur : ur;
        wr_en  = !(q_div && b_q == '0);
    end

    always_comb begin
        acc = {hi, lo};
        res = q_div ? {dr, dq} :
              (op_q == 4'd8 || op_q == 4'd9) ? acc - prod :
              (op_q == 4'd6 || op_q == 4'd7) ? acc + prod : prod;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            hi   <= '0;
            lo   <= '0;
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
        end else begin
            if (accept && is_long) begin
                cnt  <= is_div ? 6'(DIV_LAT) : 6'(MULT_LAT);
                op_q <= op;
                a_q  <= rs_val;
                b_q  <= rt_val;
            end else if (busy) begin
                cnt <= cnt - 6'd1;
            end
            if (accept && op == 4'd4) hi <= rs_val;
            if (accept && op == 4'd5) lo <= rs_val;
            if (cnt == 6'd1 && wr_en) {hi, lo} <= res;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench; driver pushes expected HI/LO per accepted op, monitor checks on commit.
module tb_muldiv_unit;
    typedef struct {
        logic [31:0] oh, ol, nh, nl;
        int          lat;
    } exp_t;

    logic        clk = 0, reset = 1, start = 0, flush = 0;
    logic [3:0]  op = 0;
    logic [31:0] rs_val = 0, rt_val = 0;
    logic        busy, stall_req;
    logic [31:0] hi, lo;

    exp_t        sb_q[$];
    int          total = 0, passed = 0;
    int          cyc = 0, busy_end = 0;
    logic [31:0] m_hi = 0, m_lo = 0;

    muldiv_unit #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .flush(flush),
        .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .stall_req(stall_req),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference behaviour written straight from the op definitions.
    function automatic logic [63:0] model(logic [3:0] o, logic [31:0] a, logic [31:0] b, logic [63:0] acc);
        logic [63:0] p;
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (o == 4 || o == 5) return o == 4 ? {a, acc[31:0]} : {acc[63:32], a};
        if (o == 2 || o == 3) begin
            if (b == 0) return acc;
            if (o == 3) return {a % b, a / b};
            if (a == 32'h80000000 && b == 32'hffffffff) return {32'h0, 32'h80000000};
            return {32'(sa % sb), 32'(sa / sb)};
        end
        p = (o == 0 || o == 6 || o == 8) ? 64'(sa * sb) : {32'h0, a} * {32'h0, b};
        if (o == 6 || o == 7) return acc + p;
        if (o == 8 || o == 9) return acc - p;
        return p;
    endfunction

    task automatic issue(logic [3:0] o, logic [31:0] a, logic [31:0] b = 0, bit fl = 0, bit push = 1);
        bit mbz, acc, lng;
        exp_t e;
        logic [63:0] r;
        mbz = cyc < busy_end;
        lng = o inside {0, 1, 2, 3, 6, 7, 8, 9};
        acc = !fl && !mbz && o <= 9;
        start = 1; op = o; rs_val = a; rt_val = b; flush = fl;
        #1 chk("stall_req", 64'(stall_req), 64'(mbz || (!fl && lng)));
        @(posedge clk); #1;
        start = 0; flush = 0;
        if (acc) begin
            r = model(o, a, b, {m_hi, m_lo});
            e = '{m_hi, m_lo, r[63:32], r[31:0], lng ? ((o == 2 || o == 3) ? 10 : 5) : 0};
            m_hi = r[63:32];
            m_lo = r[31:0];
            if (lng) busy_end = cyc + e.lat;
            if (push) sb_q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        while (cyc < busy_end) begin
            @(posedge clk); #1;
        end
        chk("idle_busy", 64'(busy), 64'(0));
    endtask

    function automatic logic [31:0] pick();
        int k = $urandom_range(0, 5);
        if (k == 0) return 32'h0;
        if (k == 1) return 32'h80000000;
        if (k == 2) return 32'hffffffff;
        return $urandom;
    endfunction

    initial begin
        exp_t e;
        int n = 0;
        bit trk = 0;
        forever begin
            @(negedge clk);
            if (trk) begin
                if (busy) begin
                    n++;
                    chk("hold_hi", 64'(hi), 64'(e.oh));
                    chk("hold_lo", 64'(lo), 64'(e.ol));
                    if (n > 70) begin
                        chk("busy_bound", 64'(n), 64'(e.lat));
                        trk = 0;
                    end
                end else begin
                    chk("busy_len", 64'(n), 64'(e.lat));
                    chk("res_hi", 64'(hi), 64'(e.nh));
                    chk("res_lo", 64'(lo), 64'(e.nl));
                    trk = 0;
                end
            end else if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (e.lat == 0) begin
                    chk("mt_busy", 64'(busy), 64'(0));
                    chk("mt_hi", 64'(hi), 64'(e.nh));
                    chk("mt_lo", 64'(lo), 64'(e.nl));
                end else begin
                    chk("busy_rise", 64'(busy), 64'(1));
                    n = 1;
                    trk = 1;
                end
            end
        end
    end

    initial begin
        start = 1; op = 0; rs_val = 32'h1234; rt_val = 32'h5;
        repeat (2) @(posedge clk);
        #1 chk("rst_stall", 64'(stall_req), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_hi", 64'(hi), 64'(0));
        chk("rst_lo", 64'(lo), 64'(0));
        reset = 0; start = 0;
        @(posedge clk); #1;

        issue(0, 32'hfffffffe, 32'h3); wait_idle();
        issue(2, 32'hfffffff9, 32'h2); wait_idle();
        issue(4, 32'h11); issue(5, 32'h22);
        issue(3, 32'h5, 32'h0); wait_idle();
        issue(2, 32'h80000000, 32'hffffffff); wait_idle();
        issue(1, 32'hffffffff, 32'hffffffff);
        repeat (3) issue(5, 32'h5);
        wait_idle();
        issue(5, 32'h5);
        issue(2, 32'h7, 32'h3, 1);
        chk("flush_busy", 64'(busy), 64'(0));
        issue(11, 32'h7, 32'h3);
        chk("rsv_busy", 64'(busy), 64'(0));
        issue(4, 32'h0); issue(5, 32'hffffffff);
        issue(7, 32'h1, 32'h1); wait_idle();
        issue(8, 32'h1, 32'h1); wait_idle();
        issue(0, 32'h7, 32'h9); wait_idle();
        issue(6, 32'hfffffff0, 32'h3); wait_idle();

        for (int i = 0; i < 80; i++) begin
            logic [3:0] o;
            logic [31:0] a, b;
            bit fl;
            o = 4'($urandom_range(0, 15));
            a = pick();
            b = pick();
            fl = $urandom_range(0, 9) == 0;
            if ($urandom_range(0, 2) != 0) wait_idle();
            issue(o, a, b, fl);
        end
        wait_idle();
        repeat (2) @(posedge clk);
        #1;

        issue(0, 32'h3, 32'h4, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1; start = 1; op = 0;
        #1 chk("rst_mid_stall", 64'(stall_req), 64'(0));
        @(posedge clk); #1;
        reset = 0; start = 0;
        m_hi = 0; m_lo = 0; busy_end = 0;
        chk("rst_mid_busy", 64'(busy), 64'(0));
        chk("rst_mid_hi", 64'(hi), 64'(0));
        chk("rst_mid_lo", 64'(lo), 64'(0));
        repeat (8) @(posedge clk);
        #1 chk("rst_late_busy", 64'(busy), 64'(0));
        chk("rst_late_hilo", {hi, lo}, 64'(0));

        repeat (3) @(posedge clk);
        chk("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
